// File: rtl/unit_tx_sched.sv
// unit_tx_sched: round-robin selection of the computing unit that receives the
// next candidate packet, with per-unit in-flight tracking and occupancy report.
// Optional build macro UNIT_SCHED_STATS_EN adds per-unit tx_done statistics
// readable through stats_unit / stats_cnt.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no reservation; waiting for req
// S_SCAN    | testing one candidate unit per cycle starting at ptr
// S_GRANT   | one-cycle grant pulse; unit_num is reserved
// S_WAIT_TX | waiting for tx_done (count it) or tx_abort (release)

module unit_tx_sched #(
  parameter int N_UNITS      = 4,
  parameter int MAX_INFLIGHT = 20,
  localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1,
  localparam int TW = $clog2(N_UNITS * MAX_INFLIGHT + 1),
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req,
  output logic               grant,
  output logic [UW-1:0]      unit_num,
  input  logic               tx_done,
  input  logic               tx_abort,
  input  logic [N_UNITS-1:0] unit_ready,
  input  logic [N_UNITS-1:0] unit_tx_mask,
  input  logic [N_UNITS-1:0] unit_rx_done,
  output logic               stall,
  output logic [TW-1:0]      total_in_flight,
  output logic               idle,
`ifdef UNIT_SCHED_STATS_EN
  input  logic [UW-1:0]      stats_unit,
  output logic [31:0]        stats_cnt,
`endif
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GRANT, S_WAIT_TX} state_t;

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_INFLIGHT);
  localparam logic [UW-1:0] LAST_U = UW'(N_UNITS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt [N_UNITS];
  logic [CW-1:0]      w_cnt_nxt [N_UNITS];
  logic [N_UNITS-1:0] r_ready;
  logic [N_UNITS-1:0] r_mask;
  logic [N_UNITS-1:0] w_elig;
  logic [N_UNITS-1:0] w_inc;
  logic [UW-1:0]      r_ptr;
  logic [UW-1:0]      r_cand;
  logic [UW-1:0]      r_scan_cnt;
  logic [UW-1:0]      r_unit_num;
  logic [UW-1:0]      w_cand_inc;
  logic [UW-1:0]      w_unit_inc;
  logic [TW-1:0]      r_total;
  logic [TW-1:0]      w_sum;
  logic               r_stall;
  logic               r_err;
  logic               w_hit;
  logic               w_tx_done_ok;
  logic               w_cnt_err;
  logic               w_err_set;

  assign w_cand_inc   = (r_cand == LAST_U) ? '0 : r_cand + UW'(1);
  assign w_unit_inc   = (r_unit_num == LAST_U) ? '0 : r_unit_num + UW'(1);
  assign w_hit        = w_elig[r_cand];
  assign w_tx_done_ok = (r_state == S_WAIT_TX) & tx_done;

  // eligibility from the registered ready/mask copies and the live counters
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      w_elig[i] = r_ready[i] & ~r_mask[i] & (r_cnt[i] < MAX_C);
    end
  end

  // per-unit counter next values; a same-cycle increment and decrement cancel
  always_comb begin
    w_cnt_err = 1'b0;
    w_inc     = '0;
    w_sum     = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      w_inc[i]     = w_tx_done_ok & (r_unit_num == UW'(i));
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc[i] && !unit_rx_done[i]) begin
        if (r_cnt[i] == MAX_C) w_cnt_err = 1'b1;
        else                   w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end else if (!w_inc[i] && unit_rx_done[i]) begin
        if (r_cnt[i] == '0) w_cnt_err = 1'b1;
        else                w_cnt_nxt[i] = r_cnt[i] - CW'(1);
      end
      w_sum = w_sum + TW'(r_cnt[i]);
    end
  end

  // any protocol violation this cycle; err latches it until reset
  always_comb begin
    w_err_set = w_cnt_err
              | ((tx_done | tx_abort) & (r_state != S_WAIT_TX))
              | (tx_done & tx_abort & (r_state == S_WAIT_TX));
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (req) w_state_nxt = S_SCAN;
      S_SCAN:    if (w_hit) w_state_nxt = S_GRANT;
      S_GRANT:   w_state_nxt = S_WAIT_TX;
      S_WAIT_TX: if (tx_done | tx_abort) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and registered status
  always_comb begin
    grant           = (r_state == S_GRANT);
    idle            = (r_state == S_IDLE) && (r_total == '0);
    unit_num        = r_unit_num;
    stall           = r_stall;
    err             = r_err;
    total_in_flight = r_total;
  end

  // scan pointer, candidate walk, stall flag, input registers and error flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ready    <= '0;
      r_mask     <= '0;
      r_ptr      <= '0;
      r_cand     <= '0;
      r_scan_cnt <= '0;
      r_unit_num <= '0;
      r_stall    <= 1'b0;
      r_err      <= 1'b0;
      r_total    <= '0;
    end else begin
      r_ready <= unit_ready;
      r_mask  <= unit_tx_mask;
      r_total <= w_sum;
      if (w_err_set) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_cand     <= r_ptr;
            r_scan_cnt <= '0;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_unit_num <= r_cand;
            r_stall    <= 1'b0;
          end else begin
            r_cand <= w_cand_inc;
            // a whole pass of N_UNITS candidates without a hit
            if (r_scan_cnt == LAST_U) begin
              r_stall    <= 1'b1;
              r_scan_cnt <= '0;
            end else begin
              r_scan_cnt <= r_scan_cnt + UW'(1);
            end
          end
        end
        S_WAIT_TX: begin
          if (tx_done) r_ptr <= w_unit_inc;
        end
        default: ;
      endcase
    end
  end

  // per-unit in-flight counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_UNITS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

`ifdef UNIT_SCHED_STATS_EN
  logic [31:0] r_stats [N_UNITS];
  logic [31:0] r_stats_cnt;

  // per-unit tx_done event counts and registered read port
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_UNITS; i++) r_stats[i] <= '0;
      r_stats_cnt <= '0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        if (w_inc[i]) r_stats[i] <= r_stats[i] + 32'd1;
      end
      r_stats_cnt <= (32'(stats_unit) < 32'(N_UNITS)) ? r_stats[stats_unit] : '0;
    end
  end

  assign stats_cnt = r_stats_cnt;
`endif

endmodule

// File: doc/unit_tx_sched.md
Name: unit_tx_sched

Overview:
- Scheduler that chooses which computing unit receives the next candidate packet.
- Sits between the transmit arbiter's packet-building FSM and the unit array, at CORE_CLK.
- Selects units round-robin among those that are ready, not masked and below their in-flight limit.
- Tracks per-unit outstanding candidates and reports aggregate occupancy.

Parameters:
- N_UNITS, 4, number of computing units (1..32).
- MAX_INFLIGHT, 20, maximum outstanding candidates per unit (N_THREADS + 4 by default).

Ports:
- CLK  in  1  core clock.
- RST  in  1  synchronous, active-high reset.
- req  in  1  transmitter requests a unit; level, held until grant.
- grant  out  1  one-cycle pulse: unit_num is valid and reserved.
- unit_num  out  `MSB(N_UNITS-1)+1  selected unit; stable from grant until tx_done/tx_abort.
- tx_done  in  1  packet to unit_num fully written; counts one candidate.
- tx_abort  in  1  reservation released without sending anything.
- unit_ready  in  N_UNITS  unit can accept a packet.
- unit_tx_mask  in  N_UNITS  1 = unit excluded from selection.
- unit_rx_done  in  N_UNITS  per-unit pulse: one candidate result returned.
- stall  out  1  a full scan pass found no eligible unit.
- total_in_flight  out  `MSB(N_UNITS*MAX_INFLIGHT)+1  sum of all per-unit counters.
- idle  out  1  state IDLE and total_in_flight == 0.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (RST high at a clock edge) clears all outputs, counters, ptr and state to 0/IDLE. Reset overrides any operation in progress, including one mid-grant.
- unit_ready and unit_tx_mask are registered once (ready_r, mask_r). Eligibility uses the registered copies: elig[i] = ready_r[i] & ~mask_r[i] & (cnt[i] < MAX_INFLIGHT).
- FSM state IDLE: when req=1, go to SCAN with cand <= ptr and scan_cnt <= 0.
- FSM state SCAN (one unit per cycle):
  - If elig[cand]: unit_num <= cand, go to GRANT.
  - Otherwise cand <= cand+1, wrapping N_UNITS-1 -> 0, and scan_cnt increments.
  - When scan_cnt reaches N_UNITS-1 with no hit, stall <= 1, scan_cnt <= 0 and scanning continues. stall clears on the cycle GRANT is entered.
- FSM state GRANT: grant=1 for exactly one cycle, then go to WAIT_TX.
- FSM state WAIT_TX:
  - On tx_done: cnt[unit_num]++, ptr <= unit_num+1 (with wrap), go to IDLE.
  - On tx_abort: no count change, ptr unchanged, go to IDLE.
  - tx_done and tx_abort together: treated as tx_done, and err set.
- Minimum latency: req in IDLE at cycle 0, SCAN at 1, grant at 2 when the unit at ptr is eligible. Each skipped unit adds 1 cycle.
- req dropping before grant: the scan still completes and grant is issued; the requester must accept it or issue tx_abort.
- Counter updates:
  - unit_rx_done[i] decrements cnt[i] in the same cycle, in every state.
  - Simultaneous tx_done increment and rx_done on the same unit: net 0.
  - rx_done with cnt[i]==0: counter stays 0, err set.
  - Increment with cnt==MAX_INFLIGHT cannot happen, because eligibility excludes it. If forced, saturate and set err.
- total_in_flight is registered, one cycle behind the counters.
- tx_done or tx_abort outside WAIT_TX: ignored, err set.
- err is cleared only by RST.

Optional Feature:
- Macro UNIT_SCHED_STATS_EN.
- Defined:
  - Adds input stats_unit (`MSB(N_UNITS-1)+1 bits) and output stats_cnt (32 bits).
  - A per-unit 32-bit count of tx_done events, wrapping at 2^32, cleared by RST.
  - stats_cnt = count[stats_unit], registered, 1-cycle read latency.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan (N_UNITS=4, MAX_INFLIGHT=2):
- After reset, all units ready/unmasked, req held, tx_done 2 cycles after each grant -> grants to units 0,1,2,3,0 in order; first grant 2 cycles after req; total_in_flight reaches 5.
- unit_tx_mask=4'b0010, ptr=1 -> unit 1 skipped, grant unit 2 at 3 cycles after req.
- Unit 0 given 2 tx_done, others not ready -> SCAN loops, stall=1 after 3 cycles. unit_rx_done[0] pulse -> grant unit 0, stall=0.
- tx_abort after grant of unit 2 -> cnt[2] unchanged, next req grants unit 2 again.
- unit_rx_done[3] with cnt[3]=0 -> err=1, cnt stays 0. Simultaneous tx_done + rx_done on unit 1 -> cnt[1] unchanged.
- RST asserted in WAIT_TX with cnt=1,2,0,1 -> next cycle: state IDLE, all counters 0, grant=0, idle=1, err=0.
